pipeline_hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage RV32I core, sitting beside the forwarding mux unit.
- Detects hazards that forwarding cannot cover: load-use, taken branch/jump redirect, and data-memory wait.
- Drives PC/IF-ID hold, EX bubble insertion, wrong-path flush and full-pipeline freeze.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout error.

---
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: resolves load-use, redirect and
// data-memory-wait hazards into hold/bubble/flush/freeze controls, with saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter bit          debug_param  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_stage0,
    input  logic [4:0]  rs2_stage0,
    input  logic        uses_rs1_stage0,
    input  logic        uses_rs2_stage0,
    input  logic [4:0]  destination_reg_stage1,
    input  logic        mem_read_stage1,
    input  logic        branch_taken_stage1,
    input  logic        mem_busy,
    output logic        stall_pc,
    output logic        bubble_stage1,
    output logic        flush_stage0,
    output logic        freeze_all,
    output logic [1:0]  ctrl_state,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StFlush   = 2'b01,
        StMemWait = 2'b10
    } state_e;

    localparam logic [2:0]  FlushLeft  = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] MemTimeout = 16'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [2:0]  flush_left_q, flush_left_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        timeout_q, timeout_d;

    logic load_use;
    logic stall_c, bubble_c, flush_c, freeze_c;

    assign load_use = mem_read_stage1 && (destination_reg_stage1 != 5'd0) &&
                      ((uses_rs1_stage0 && (rs1_stage0 == destination_reg_stage1)) ||
                       (uses_rs2_stage0 && (rs2_stage0 == destination_reg_stage1)));

    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        stall_c      = 1'b0;
        bubble_c     = 1'b0;
        flush_c      = 1'b0;
        freeze_c     = 1'b0;

        // Consecutive busy cycles, regardless of which state the freeze lands in.
        if (!mem_busy) begin
            wait_cnt_d = 16'd0;
        end else if (wait_cnt_q != MemTimeout) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        timeout_d = timeout_q || (mem_busy && (wait_cnt_d == MemTimeout));

        unique case (state_q)
            StRun, StMemWait: begin
                if (mem_busy) begin
                    freeze_c = 1'b1;
                    state_d  = StMemWait;
                end else if (branch_taken_stage1) begin
                    // Decode holds a wrong-path instruction, so any load_use is irrelevant.
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d      = StFlush;
                        flush_left_d = FlushLeft;
                    end else begin
                        state_d = StRun;
                    end
                end else if (load_use) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
                    state_d = StRun;
                end else begin
                    state_d = StRun;
                end
            end
            StFlush: begin
                // Flush controls stay asserted under a freeze; the freeze holds the registers.
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                if (mem_busy) begin
                    freeze_c = 1'b1;
                end else begin
                    flush_left_d = flush_left_q - 3'd1;
                    if (flush_left_q <= 3'd1) state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            flush_left_q <= 3'd0;
            wait_cnt_q   <= 16'd0;
            stall_cnt_q  <= 16'd0;
            flush_cnt_q  <= 16'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            wait_cnt_q   <= wait_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    // Controls are forced low for as long as reset is held, independent of the inputs.
    assign stall_pc      = rst_n && stall_c;
    assign bubble_stage1 = rst_n && bubble_c;
    assign flush_stage0  = rst_n && flush_c;
    assign freeze_all    = rst_n && freeze_c;
    assign ctrl_state    = state_q;
    assign stall_count   = stall_cnt_q;
    assign flush_count   = flush_cnt_q;
    assign timeout_err   = timeout_q;

    always @(negedge clk) begin
        if (debug_param && rst_n) begin
            if (freeze_c) begin
                $write("[%0t] hazard: freeze state=%0d wait=%0d timeout=%0d stalls=%0d flushes=%0d\n",
                       $time, state_q, wait_cnt_q, timeout_q, stall_cnt_q, flush_cnt_q);
            end else if (flush_c) begin
                $write("[%0t] hazard: flush state=%0d left=%0d stalls=%0d flushes=%0d\n",
                       $time, state_q, flush_left_q, stall_cnt_q, flush_cnt_q);
            end else if (stall_c) begin
                $write("[%0t] hazard: load-use rd=x%0d rs1=x%0d rs2=x%0d stalls=%0d flushes=%0d\n",
                       $time, destination_reg_stage1, rs1_stage0, rs2_stage0, stall_cnt_q,
                       flush_cnt_q);
            end
        end
    end

endmodule
